// File: rtl/clock_ctrl.sv
// Sequencer for the 12-hour BCD time-of-day counter: 1 Hz enable prescaler,
// button-driven time/alarm setting FSM, display mux and alarm match.
module clock_ctrl #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       al_en,
  input  logic       cur_pm,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  output logic       ena,
  output logic       ld,
  output logic       ld_pm,
  output logic [7:0] ld_hh,
  output logic [7:0] ld_mm,
  output logic [2:0] mode,
  output logic       disp_pm,
  output logic [7:0] disp_hh,
  output logic [7:0] disp_mm,
  output logic       alarm
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    StRun   = 3'd0,
    StSetHh = 3'd1,
    StSetMm = 3'd2,
    StSetAh = 3'd3,
    StSetAm = 3'd4
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      e_hh_q, e_mm_q, a_hh_q, a_mm_q;
  logic            e_pm_q, a_pm_q;
  logic            silence_q, silence_d;
  logic            match;

  // Seconds never take part in the alarm match.
  logic unused_ss;
  assign unused_ss = ^cur_ss;

  // 12 -> 01 -> ... -> 09 -> 10 -> 11 -> 12, always legal BCD.
  function automatic logic [7:0] hr_next(input logic [7:0] h);
    if (h == 8'h12)      return 8'h01;
    else if (h == 8'h09) return 8'h10;
    else                 return h + 8'h01;
  endfunction

  function automatic logic [7:0] min_next(input logic [7:0] m);
    if (m == 8'h59)           return 8'h00;
    else if (m[3:0] == 4'h9)  return {m[7:4] + 4'h1, 4'h0};
    else                      return {m[7:4], m[3:0] + 4'h1};
  endfunction

  assign match = al_en && (state_q == StRun) && (cur_hh == a_hh_q) &&
                 (cur_mm == a_mm_q) && (cur_pm == a_pm_q);

  // Silence is set by inc during a match and self-clears once the match ends;
  // alarm uses the next-state value so a silencing press drops it immediately.
  always_comb begin
    silence_d = silence_q;
    if (!match) begin
      silence_d = 1'b0;
    end else if (btn_inc && !btn_mode) begin
      silence_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      ena       <= 1'b0;
      ld        <= 1'b0;
      e_hh_q    <= 8'h12;
      e_mm_q    <= 8'h00;
      e_pm_q    <= 1'b0;
      a_hh_q    <= 8'h12;
      a_mm_q    <= 8'h00;
      a_pm_q    <= 1'b0;
      alarm     <= 1'b0;
      silence_q <= 1'b0;
    end else begin
      ena       <= (state_q == StRun) && (cnt_q == CntMax);
      ld        <= 1'b0;
      silence_q <= silence_d;
      alarm     <= match && !silence_d;

      if (state_q == StRun) begin
        cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
      end else begin
        cnt_q <= '0;
      end

      if (btn_mode) begin
        unique case (state_q)
          StRun: begin
            state_q <= StSetHh;
            e_hh_q  <= cur_hh;
            e_mm_q  <= cur_mm;
            e_pm_q  <= cur_pm;
          end
          StSetHh: state_q <= StSetMm;
          StSetMm: begin
            state_q <= StSetAh;
            ld      <= 1'b1;
          end
          StSetAh: state_q <= StSetAm;
          StSetAm: state_q <= StRun;
          default: state_q <= StRun;
        endcase
      end else if (btn_inc) begin
        unique case (state_q)
          StSetHh: begin
            e_hh_q <= hr_next(e_hh_q);
            if (e_hh_q == 8'h11) e_pm_q <= !e_pm_q;
          end
          StSetMm: e_mm_q <= min_next(e_mm_q);
          StSetAh: begin
            a_hh_q <= hr_next(a_hh_q);
            if (a_hh_q == 8'h11) a_pm_q <= !a_pm_q;
          end
          StSetAm: a_mm_q <= min_next(a_mm_q);
          default: ;
        endcase
      end
    end
  end

  assign mode  = state_q;
  assign ld_hh = e_hh_q;
  assign ld_mm = e_mm_q;
  assign ld_pm = e_pm_q;

  always_comb begin
    disp_hh = cur_hh;
    disp_mm = cur_mm;
    disp_pm = cur_pm;
    unique case (state_q)
      StSetHh, StSetMm: begin
        disp_hh = e_hh_q;
        disp_mm = e_mm_q;
        disp_pm = e_pm_q;
      end
      StSetAh, StSetAm: begin
        disp_hh = a_hh_q;
        disp_mm = a_mm_q;
        disp_pm = a_pm_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
Control and sequencing block for the 12-hour BCD time-of-day counter. It generates the counter's 1 Hz enable from the system clock and runs a button-driven FSM for setting the time and an alarm. It loads edited time into the counter with a one-cycle strobe, muxes display values, and raises an alarm on a time match. It sits between the debounced front-panel buttons and the time-of-day counter.

Parameters:
TICK_DIV, 50000000, clk cycles per ena pulse (1 s); legal range >= 2.

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
btn_mode  in  1  debounced single-cycle pulse: advance mode
btn_inc  in  1  debounced single-cycle pulse: increment field / silence alarm
al_en  in  1  alarm enable level
cur_pm  in  1  counter PM flag
cur_hh  in  8  counter hours, BCD 01..12
cur_mm  in  8  counter minutes, BCD 00..59
cur_ss  in  8  counter seconds, BCD 00..59
ena  out  1  one-cycle count enable to counter
ld  out  1  one-cycle load strobe to counter (counter loads ld_hh/ld_mm/ld_pm, ss := 00)
ld_pm  out  1  edit PM value
ld_hh  out  8  edit hours, BCD
ld_mm  out  8  edit minutes, BCD
mode  out  3  0 RUN, 1 SET_HH, 2 SET_MM, 3 SET_AH, 4 SET_AM
disp_pm  out  1  display PM
disp_hh  out  8  display hours
disp_mm  out  8  display minutes
alarm  out  1  alarm active

Behaviour:
- Reset values: state RUN (mode 0), prescaler cnt 0, ena 0, ld 0, edit regs e_hh 8'h12, e_mm 8'h00, e_pm 0. Alarm regs a_hh 8'h12, a_mm 8'h00, a_pm 0. alarm 0, silence flag 0.
- Reset mid-edit discards edits; no ld is issued.
- Prescaler: runs only in RUN. cnt counts 0..TICK_DIV-1 and wraps. ena is registered: ena <= (state==RUN && cnt==TICK_DIV-1).
- After reset release, ena is high after edges TICK_DIV, 2*TICK_DIV, and so on.
- In any SET state: cnt held at 0, ena 0.
- FSM transitions, on btn_mode only:
  - RUN -> SET_HH: captures cur_hh/cur_mm/cur_pm into e_hh/e_mm/e_pm on the same edge.
  - SET_HH -> SET_MM.
  - SET_MM -> SET_AH: ld=1 for exactly one cycle, in the cycle after the edge. ld_* hold the edit values throughout.
  - SET_AH -> SET_AM.
  - SET_AM -> RUN: cnt restarts at 0, so the first ena comes TICK_DIV edges later.
- btn_mode and btn_inc in the same cycle: mode wins, inc ignored.
- btn_inc, hour fields (SET_HH edits e_hh/e_pm; SET_AH edits a_hh/a_pm):
  - BCD sequence 12 -> 01 -> 02 -> ... -> 09 -> 10 -> 11 -> 12.
  - The PM flag toggles on the 11 -> 12 step only.
- btn_inc, minute fields (SET_MM edits e_mm; SET_AM edits a_mm): BCD 00..59, 59 -> 00, no carry into hours.
- All BCD values stay legal; no binary intermediate ever appears on outputs.
- ld_hh/ld_mm/ld_pm drive e_hh/e_mm/e_pm continuously.
- disp_* (combinational mux):
  - RUN: cur_*.
  - SET_HH/SET_MM: e_*.
  - SET_AH/SET_AM: a_*.
- Alarm match: m = al_en && state==RUN && cur_hh==a_hh && cur_mm==a_mm && cur_pm==a_pm.
  - alarm <= m && !silence (registered, one-cycle latency).
- Silence:
  - btn_inc in RUN while m sets silence.
  - silence clears in the cycle m is 0.
  - btn_inc in RUN without m has no effect.
- alarm drops one cycle after leaving RUN or after al_en falls. cur_ss is unused for matching; alarm lasts the whole matching minute.

Test Plan:
- TICK_DIV=4, reset 3 cycles then release -> ena high exactly after edges 4, 8, 12; ld=0; disp follows cur_*.
- cur=11:59 PM, mode; inc x1 (hh 12, pm 0); mode; inc x2 (mm 01); mode -> one ld pulse with ld_hh=8'h12, ld_mm=8'h01, ld_pm=0. ena stays 0 throughout SET.
- SET_MM from e_mm=8'h58: inc x2 -> 8'h59 then 8'h00; e_hh unchanged. SET_HH from 8'h09: inc -> 8'h10, no pm change.
- Set alarm to 07:30 AM, return to RUN, al_en=1, drive cur=07:30 AM -> alarm=1 next cycle. btn_inc -> alarm 0 next cycle. cur -> 07:31 then back to 07:30 -> alarm re-asserts.
- btn_mode and btn_inc together in SET_HH -> state SET_MM, e_hh unchanged. Reset asserted in SET_MM -> RUN, e_* = 12:00 AM, no ld.
- Return SET_AM -> RUN at edge k -> next ena after edge k+4 (TICK_DIV=4).
